// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared state encoding, pooling-mode encodings and helpers
//               for the pooling engine.
// Revision    : 1.0
// ============================================================================
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic POOL_AVG = 1'b0;
    localparam logic POOL_MAX = 1'b1;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_acc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pool_acc_unit
// Description : Combinational accumulate / compare step for one pooling
//               window entry.
// Revision    : 1.0
// ============================================================================
module pool_acc_unit
    import nn_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int WIN   = 2
) (
    input  logic                           first,
    input  logic [PIX_W+2*clog2(WIN)-1:0]  acc,
    input  logic [PIX_W-1:0]               pixel,
    input  logic                           mode,
    output logic [PIX_W+2*clog2(WIN)-1:0]  result
);

    localparam int c_ACC_W = PIX_W + 2 * clog2(WIN);

    logic [c_ACC_W-1:0] w_pix_ext;

    assign w_pix_ext = c_ACC_W'(pixel);

    always_comb begin
        result = w_pix_ext;
        if (!first) begin
            if (mode == POOL_MAX) begin
                result = (w_pix_ext > acc) ? w_pix_ext : acc;
            end else begin
                result = acc + w_pix_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nn_pool_engine.sv
`default_nettype none
// ============================================================================
// Module      : nn_pool_engine
// Description : Streaming WIN x WIN average / max pooling over a raster-order
//               image, one accumulator per pooled column.
// Revision    : 1.0
// ============================================================================
module nn_pool_engine
    import nn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int WIN   = 2,
    parameter int PIX_W = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int c_LOG_WIN = clog2(WIN);
    localparam int c_ACC_W   = PIX_W + 2 * c_LOG_WIN;
    localparam int c_NUM_K   = IMG_W / WIN;
    localparam int c_COL_W   = clog2(IMG_W);
    localparam int c_ROW_W   = clog2(IMG_H);
    localparam int c_K_W     = (c_NUM_K > 1) ? clog2(c_NUM_K) : 1;

    localparam logic [c_COL_W-1:0]   c_COL_LAST   = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0]   c_ROW_LAST   = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0]   c_COL_ONE    = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0]   c_ROW_ONE    = c_ROW_W'(1);
    localparam logic [c_LOG_WIN-1:0] c_PHASE_LAST = c_LOG_WIN'(WIN - 1);

    generate
        if ((IMG_W % WIN) != 0) begin : g_bad_img_w
            $error("nn_pool_engine: IMG_W must be a multiple of WIN");
        end
        if ((IMG_H % WIN) != 0) begin : g_bad_img_h
            $error("nn_pool_engine: IMG_H must be a multiple of WIN");
        end
        if ((WIN < 2) || (WIN > 8) || ((WIN & (WIN - 1)) != 0)) begin : g_bad_win
            $error("nn_pool_engine: WIN must be a power of two in 2..8");
        end
        if (OUT_W < PIX_W) begin : g_bad_out_w
            $error("nn_pool_engine: OUT_W must be >= PIX_W");
        end
    endgenerate

    state_t             r_state;
    logic               r_mode;
    logic               r_busy;
    logic               r_done;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_ACC_W-1:0] r_acc [c_NUM_K];
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_last;

    logic               w_accept;
    logic [c_K_W-1:0]   w_k;
    logic               w_first;
    logic               w_complete;
    logic               w_last_pix;
    logic [c_ACC_W-1:0] w_acc_cur;
    logic [c_ACC_W-1:0] w_res;
    logic [c_ACC_W-1:0] w_shifted;
    logic [OUT_W-1:0]   w_pooled;

    // Stall intake only while a finished result is still waiting downstream.
    assign in_ready   = (r_state == ST_RUN) && !(r_out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_k        = c_K_W'(r_col >> c_LOG_WIN);
    assign w_first    = (r_row[c_LOG_WIN-1:0] == '0) && (r_col[c_LOG_WIN-1:0] == '0);
    assign w_complete = (r_row[c_LOG_WIN-1:0] == c_PHASE_LAST) &&
                        (r_col[c_LOG_WIN-1:0] == c_PHASE_LAST);
    assign w_last_pix = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
    assign w_acc_cur  = r_acc[w_k];
    assign w_shifted  = w_res >> (2 * c_LOG_WIN);
    assign w_pooled   = OUT_W'((r_mode == POOL_MAX) ? w_res : w_shifted);

    pool_acc_unit #(
        .PIX_W (PIX_W),
        .WIN   (WIN)
    ) u_acc_unit (
        .first  (w_first),
        .acc    (w_acc_cur),
        .pixel  (in_data),
        .mode   (r_mode),
        .result (w_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_mode  <= POOL_AVG;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_mode  <= mode;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept && w_last_pix) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_out_valid && out_ready && r_out_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < c_NUM_K; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                r_acc[w_k] <= w_res;
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_ONE;
                end else begin
                    r_col <= r_col + c_COL_ONE;
                end
            end

            // A completing window reloads the register even as the old value drains.
            if (w_accept && w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pooled;
                r_out_last  <= w_last_pix;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
